sram_ctrl: RTL and testbench

- Initiator-side controller for the asynchronous external SRAM: word-addressed, 32-bit data, per-byte enables, active-low ce/oe/we.
- Converts a single-outstanding CPU/MMU memory request (req/ack handshake) into correctly sequenced SRAM strobes.
- Owns the bidirectional data bus: drives it on writes, tri-states it otherwise, and captures read data into a register.
- Sits between the memory arbiter and the board SRAM pins (base or ext bank).

---
 rtl/sram_ctrl_pkg.sv | 31 +++
 rtl/sram_ctrl_if.sv | 37 +++
 rtl/sram_ctrl.sv | 174 +++++++++++++++++
 tb/tb_sram_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg: shared types and constants for the external SRAM controller.
//   Word_t      32-bit data word
//   Ram_addr_t  20-bit SRAM word address
//   Mask_t      4-bit byte mask (bit i covers data[8i+7:8i])
//   Bit_t       single control bit
//   SramCtrlState_t  controller FSM states
//   SRAM_WAIT_W      width of the wait-state counter
package sram_ctrl_pkg;

  typedef logic [31:0] Word_t;
  typedef logic [19:0] Ram_addr_t;
  typedef logic [3:0]  Mask_t;
  typedef logic        Bit_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WRITE = 3'd2,
    WHOLD = 3'd3,
    DONE  = 3'd4
  } SramCtrlState_t;

  // Wide enough for any sensible WAIT_CYCLES setting (0..255).
  localparam int SRAM_WAIT_W = 8;

  // True in states where the chip is selected.
  function automatic Bit_t chip_selected(input SramCtrlState_t s);
    return (s == READ) || (s == WRITE) || (s == WHOLD);
  endfunction

endpackage

// File: rtl/sram_ctrl_if.sv
// sram_ctrl_if: request-side bus between the memory arbiter and sram_ctrl.
//   req    request valid; the requester holds it high until ack
//   we     1 = write, 0 = read
//   addr   word address
//   be     byte enables, active-high
//   wdata  write data
//   rdata  read data, valid in the ack cycle of a read
//   ack    one-cycle completion pulse
//   busy   controller is not idle
// Handshake: a request is accepted on the first rising edge where req is
// high and the controller is idle; address/data/mask are latched on that
// edge and ignored afterwards. The transaction ends with exactly one ack
// cycle. The controller never accepts in the cycle of its own ack, so at
// least one idle cycle separates two transactions.
interface sram_ctrl_if;
  import sram_ctrl_pkg::*;

  Bit_t      req;
  Bit_t      we;
  Ram_addr_t addr;
  Mask_t     be;
  Word_t     wdata;
  Word_t     rdata;
  Bit_t      ack;
  Bit_t      busy;

  modport master (
    output req, we, addr, be, wdata,
    input  rdata, ack, busy
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output rdata, ack, busy
  );

endinterface

// File: rtl/sram_ctrl.sv
// sram_ctrl: initiator-side controller for an asynchronous external SRAM.
// Turns one outstanding request from the bus interface into a sequenced
// ce/oe/we strobe pattern, drives the data bus only while writing and
// captures read data into a holding register.
//
// Ports:
//   clk, rst    system clock, asynchronous active-high reset
//   bus         sram_ctrl_if.slave request interface
//   ram_data    bidirectional SRAM data bus
//   ram_addr    SRAM word address
//   ram_be_n    byte enables, active-low
//   ram_ce_n    chip select, active-low
//   ram_oe_n    output enable, active-low
//   ram_we_n    write enable, active-low
//   state_o     current FSM state (debug)
//   rd_cnt/wr_cnt  completed read/write counters, only when
//                  SRAM_CTRL_PERF_CNT_EN is defined
//
// Parameter WAIT_CYCLES: extra cycles per strobe phase, so the read and
// write strobe phases each last WAIT_CYCLES+1 cycles.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 0
) (
  input  logic           clk,
  input  logic           rst,
  sram_ctrl_if.slave     bus,
  inout  wire [31:0]     ram_data,
  output Ram_addr_t      ram_addr,
  output Mask_t          ram_be_n,
  output logic           ram_ce_n,
  output logic           ram_oe_n,
  output logic           ram_we_n,
  output SramCtrlState_t state_o
`ifdef SRAM_CTRL_PERF_CNT_EN
  ,
  output Word_t          rd_cnt,
  output Word_t          wr_cnt
`endif
);

  localparam logic [SRAM_WAIT_W-1:0] WAIT_LOAD = SRAM_WAIT_W'(WAIT_CYCLES);

  SramCtrlState_t         state_q, state_d;
  logic                   we_q, we_d;
  Ram_addr_t              addr_q, addr_d;
  Mask_t                  be_q, be_d;
  Word_t                  wdata_q, wdata_d;
  logic [SRAM_WAIT_W-1:0] cnt_q, cnt_d;
  Word_t                  rdata_q, rdata_d;

  // Pin registers, loaded from the next state so the strobes line up with
  // the state they belong to and never see a combinational path from req.
  logic  ce_n_q, ce_n_d;
  logic  oe_n_q, oe_n_d;
  logic  we_n_q, we_n_d;
  Mask_t be_n_q, be_n_d;
  logic  drive_q, drive_d;
  logic  ack_q, ack_d;

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          be_d    = bus.be;
          wdata_d = bus.wdata;
          cnt_d   = WAIT_LOAD;
          state_d = bus.we ? WRITE : READ;
        end
      end
      READ: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - SRAM_WAIT_W'(1);
        end else begin
          rdata_d = ram_data;
          state_d = DONE;
        end
      end
      WRITE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - SRAM_WAIT_W'(1);
        end else begin
          state_d = WHOLD;
        end
      end
      // One extra cycle with we_n released but data still driven gives the
      // SRAM its data hold time.
      WHOLD:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ce_n_d  = !chip_selected(state_d);
    oe_n_d  = (state_d != READ);
    we_n_d  = (state_d != WRITE);
    be_n_d  = chip_selected(state_d) ? ~be_d : 4'b1111;
    drive_d = (state_d == WRITE) || (state_d == WHOLD);
    ack_d   = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      be_q    <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      ce_n_q  <= 1'b1;
      oe_n_q  <= 1'b1;
      we_n_q  <= 1'b1;
      be_n_q  <= 4'b1111;
      drive_q <= 1'b0;
      ack_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      ce_n_q  <= ce_n_d;
      oe_n_q  <= oe_n_d;
      we_n_q  <= we_n_d;
      be_n_q  <= be_n_d;
      drive_q <= drive_d;
      ack_q   <= ack_d;
    end
  end

  assign ram_data  = drive_q ? wdata_q : 'z;
  assign ram_addr  = addr_q;
  assign ram_be_n  = be_n_q;
  assign ram_ce_n  = ce_n_q;
  assign ram_oe_n  = oe_n_q;
  assign ram_we_n  = we_n_q;
  assign state_o   = state_q;

  assign bus.rdata = rdata_q;
  assign bus.ack   = ack_q;
  assign bus.busy  = (state_q != IDLE);

`ifdef SRAM_CTRL_PERF_CNT_EN
  Word_t rd_cnt_q, wr_cnt_q;

  // we_q still holds the latched direction during the ack cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else if (ack_q) begin
      if (we_q) wr_cnt_q <= wr_cnt_q + 32'd1;
      else      rd_cnt_q <= rd_cnt_q + 32'd1;
    end
  end

  assign rd_cnt = rd_cnt_q;
  assign wr_cnt = wr_cnt_q;
`endif

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: two controllers (WAIT_CYCLES = 0 and 2), each wired to a
// small behavioural SRAM, driven through per-scenario tasks and checked
// cycle by cycle against a timeline and a word-level memory model.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-controller stimulus (index 0: WAIT_CYCLES=0, index 1: WAIT_CYCLES=2)
  logic        rst_a   [2];
  logic        req_a   [2];
  logic        we_a    [2];
  logic [19:0] addr_a  [2];
  logic [3:0]  be_a    [2];
  logic [31:0] wdata_a [2];
  logic        mem_clr;

  sram_ctrl_if bus0 ();
  sram_ctrl_if bus1 ();

  assign bus0.req = req_a[0];  assign bus1.req = req_a[1];
  assign bus0.we  = we_a[0];   assign bus1.we  = we_a[1];
  assign bus0.addr = addr_a[0]; assign bus1.addr = addr_a[1];
  assign bus0.be  = be_a[0];   assign bus1.be  = be_a[1];
  assign bus0.wdata = wdata_a[0]; assign bus1.wdata = wdata_a[1];

  wire [31:0] ram_data0, ram_data1;
  logic [19:0] ram_addr0, ram_addr1;
  logic [3:0]  ram_be_n0, ram_be_n1;
  logic ce_n0, oe_n0, we_n0, ce_n1, oe_n1, we_n1;
  SramCtrlState_t state0, state1;
`ifdef SRAM_CTRL_PERF_CNT_EN
  logic [31:0] rd_cnt0, wr_cnt0, rd_cnt1, wr_cnt1;
`endif

  sram_ctrl #(.WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst(rst_a[0]), .bus(bus0.slave),
    .ram_data(ram_data0), .ram_addr(ram_addr0), .ram_be_n(ram_be_n0),
    .ram_ce_n(ce_n0), .ram_oe_n(oe_n0), .ram_we_n(we_n0), .state_o(state0)
`ifdef SRAM_CTRL_PERF_CNT_EN
    , .rd_cnt(rd_cnt0), .wr_cnt(wr_cnt0)
`endif
  );

  sram_ctrl #(.WAIT_CYCLES(2)) u_dut1 (
    .clk(clk), .rst(rst_a[1]), .bus(bus1.slave),
    .ram_data(ram_data1), .ram_addr(ram_addr1), .ram_be_n(ram_be_n1),
    .ram_ce_n(ce_n1), .ram_oe_n(oe_n1), .ram_we_n(we_n1), .state_o(state1)
`ifdef SRAM_CTRL_PERF_CNT_EN
    , .rd_cnt(rd_cnt1), .wr_cnt(wr_cnt1)
`endif
  );

  // Behavioural asynchronous SRAMs (256 words each, address bits [7:0]).
  logic [31:0] mem0 [256];
  logic [31:0] mem1 [256];

  assign ram_data0 = (!ce_n0 && !oe_n0) ? mem0[ram_addr0[7:0]] : 'z;
  assign ram_data1 = (!ce_n1 && !oe_n1) ? mem1[ram_addr1[7:0]] : 'z;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem0[i] <= '0;
    end else if (!ce_n0 && !we_n0) begin
      for (int i = 0; i < 4; i++)
        if (!ram_be_n0[i]) mem0[ram_addr0[7:0]][8*i +: 8] <= ram_data0[8*i +: 8];
    end
  end

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < 256; i++) mem1[i] <= '0;
    end else if (!ce_n1 && !we_n1) begin
      for (int i = 0; i < 4; i++)
        if (!ram_be_n1[i]) mem1[ram_addr1[7:0]][8*i +: 8] <= ram_data1[8*i +: 8];
    end
  end

  // Observation views, one entry per controller.
  // pins = {ce_n, oe_n, we_n, be_n[3:0], ack, busy}
  logic [8:0]  pins_w  [2];
  logic [19:0] raddr_w [2];
  logic [31:0] data_w  [2];
  logic [31:0] rdata_w [2];
  SramCtrlState_t state_w [2];

  assign pins_w[0]  = {ce_n0, oe_n0, we_n0, ram_be_n0, bus0.ack, bus0.busy};
  assign pins_w[1]  = {ce_n1, oe_n1, we_n1, ram_be_n1, bus1.ack, bus1.busy};
  assign raddr_w[0] = ram_addr0;
  assign raddr_w[1] = ram_addr1;
  assign data_w[0]  = ram_data0;
  assign data_w[1]  = ram_data1;
  assign rdata_w[0] = bus0.rdata;
  assign rdata_w[1] = bus1.rdata;
  assign state_w[0] = state0;
  assign state_w[1] = state1;

  // Reference model: word contents and the last completed read value.
  logic [31:0] ref_mem [2][256];
  logic [31:0] last_rd [2];

  function automatic logic [31:0] merge(input logic [31:0] old_v,
                                        input logic [31:0] d,
                                        input logic [3:0]  b);
    logic [31:0] r;
    r = old_v;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  // One transaction. The strobe phase lasts n = WAIT_CYCLES+1 cycles; a
  // read acks n+1 cycles after the accept edge, a write n+2. With b2b the
  // request is raised during the previous ack cycle, so one idle cycle
  // comes first. Each cycle is checked half a clock after its edge.
  task automatic do_txn(input int s, input bit w, input logic [19:0] a,
                        input logic [3:0] b, input logic [31:0] d,
                        input bit b2b, input bit scramble,
                        input bit alt_en, input logic [31:0] alt_v);
    int n, last, p;
    logic [8:0]  exp_pins;
    logic [31:0] exp_rd;
    n      = (s == 0) ? 1 : 3;
    last   = (w ? n + 2 : n + 1) + (b2b ? 1 : 0);
    exp_rd = ref_mem[s][a[7:0]];
    if (!b2b) @(negedge clk);
    we_a[s] = w; addr_a[s] = a; be_a[s] = b; wdata_a[s] = d; req_a[s] = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      p = c - (b2b ? 1 : 0);
      if (scramble && p == 1) begin
        addr_a[s]  = a ^ 20'h00055;
        wdata_a[s] = ~d;
        be_a[s]    = ~b;
      end
      if (p < 1)                         exp_pins = {3'b111, 4'b1111, 2'b00};
      else if (p == last - (b2b ? 1 : 0)) exp_pins = {3'b111, 4'b1111, 2'b11};
      else if (!w)                       exp_pins = {3'b001, ~b, 2'b01};
      else if (p <= n)                   exp_pins = {3'b010, ~b, 2'b01};
      else                               exp_pins = {3'b011, ~b, 2'b01};
      n_checks++;
      if (pins_w[s] !== exp_pins) begin
        n_fail++;
        $display("FAIL pins dut%0d we=%0d cyc%0d: got %b expected %b", s, w, p, pins_w[s], exp_pins);
      end
      if (p >= 1 && p < last - (b2b ? 1 : 0)) begin
        n_checks++;
        if (raddr_w[s] !== a) begin
          n_fail++;
          $display("FAIL ram_addr dut%0d cyc%0d: got %h expected %h", s, p, raddr_w[s], a);
        end
      end
      if (w && p >= 1 && p <= n + 1) begin
        n_checks++;
        if (data_w[s] !== d) begin
          n_fail++;
          $display("FAIL ram_data dut%0d cyc%0d: got %h expected %h", s, p, data_w[s], d);
        end
      end
      if (c == last) begin
        n_checks++;
        if (!w) begin
          if (alt_en && rdata_w[s] === alt_v) exp_rd = alt_v;
          if (rdata_w[s] !== exp_rd) begin
            n_fail++;
            $display("FAIL rdata dut%0d addr %h: got %h expected %h", s, a, rdata_w[s], exp_rd);
          end
          last_rd[s] = exp_rd;
        end else if (rdata_w[s] !== last_rd[s]) begin
          n_fail++;
          $display("FAIL rdata_hold dut%0d: got %h expected %h", s, rdata_w[s], last_rd[s]);
        end
        req_a[s] = 1'b0;
      end
    end
    if (w) ref_mem[s][a[7:0]] = merge(ref_mem[s][a[7:0]], d, b);
  endtask

  task automatic check_idle_after_reset(input int s, input string tag);
    n_checks++;
    if (pins_w[s] !== {3'b111, 4'b1111, 2'b00} || state_w[s] !== IDLE ||
        raddr_w[s] !== 20'h0 || rdata_w[s] !== 32'h0) begin
      n_fail++;
      $display("FAIL %s dut%0d: pins %b state %0d addr %h rdata %h expected 111111100 IDLE 0 0",
               tag, s, pins_w[s], state_w[s], raddr_w[s], rdata_w[s]);
    end
  endtask

  task automatic test_reset;
    for (int s = 0; s < 2; s++) begin
      req_a[s] = 0; we_a[s] = 0; addr_a[s] = '0; be_a[s] = '0; wdata_a[s] = '0;
      last_rd[s] = '0;
      for (int i = 0; i < 256; i++) ref_mem[s][i] = '0;
    end
    mem_clr = 1'b1;
    rst_a[0] = 1'b1; rst_a[1] = 1'b1;
    repeat (3) @(negedge clk);
    check_idle_after_reset(0, "reset");
    check_idle_after_reset(1, "reset");
    mem_clr = 1'b0;
    rst_a[0] = 1'b0; rst_a[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read(input int s);
    do_txn(s, 1, 20'h00010, 4'b1111, 32'hDEADBEEF, 0, 0, 0, '0);
    do_txn(s, 0, 20'h00010, 4'b1111, 32'h0, 0, 0, 0, '0);
    n_checks++;
    if (last_rd[s] !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL full_word dut%0d: got %h expected DEADBEEF", s, last_rd[s]);
    end
  endtask

  task automatic test_byte_write(input int s);
    do_txn(s, 1, 20'h00010, 4'b0010, 32'h0000AA00, 0, 0, 0, '0);
    do_txn(s, 0, 20'h00010, 4'b1111, 32'h0, 0, 0, 0, '0);
    do_txn(s, 1, 20'h00010, 4'b0000, 32'h12345678, 0, 0, 0, '0);
    do_txn(s, 0, 20'h00010, 4'b1111, 32'h0, 0, 0, 0, '0);
    n_checks++;
    if (rdata_w[s] !== 32'hDEADAAEF) begin
      n_fail++;
      $display("FAIL byte_write dut%0d: got %h expected DEADAAEF", s, rdata_w[s]);
    end
  endtask

  task automatic test_latched_inputs(input int s);
    logic [31:0] d;
    d = $urandom;
    do_txn(s, 1, 20'h00033, 4'b1111, d, 0, 1, 0, '0);
    do_txn(s, 0, 20'h00033, 4'b0101, 32'h0, 0, 1, 0, '0);
    n_checks++;
    if (ref_mem[s][8'h66] !== 32'h0 && mem0[8'h66] !== 32'h0) begin
      n_fail++;
      $display("FAIL latched_addr dut%0d: scrambled address was written", s);
    end
  endtask

  task automatic test_back_to_back(input int s);
    do_txn(s, 0, 20'h00010, 4'b1111, 32'h0, 0, 0, 0, '0);
    do_txn(s, 1, 20'h00011, 4'b1111, 32'hCAFEF00D, 1, 0, 0, '0);
    do_txn(s, 0, 20'h00011, 4'b1111, 32'h0, 1, 0, 0, '0);
    do_txn(s, 0, 20'h00010, 4'b1111, 32'h0, 1, 0, 0, '0);
  endtask

  task automatic test_random;
    int s, prev_s;
    bit w, b2b;
    prev_s = -1;
    for (int k = 0; k < 40; k++) begin
      s   = $urandom_range(0, 1);
      w   = $urandom_range(0, 1);
      b2b = (s == prev_s) && ($urandom_range(0, 2) == 0);
      do_txn(s, w, 20'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             $urandom, b2b, $urandom_range(0, 1), 0, '0);
      prev_s = s;
    end
  endtask

  task automatic test_reset_mid_write;
    logic [31:0] old_v, new_v;
    old_v = ref_mem[0][8'h20];
    new_v = $urandom;
    @(negedge clk);
    we_a[0] = 1; addr_a[0] = 20'h00020; be_a[0] = 4'b1111; wdata_a[0] = new_v; req_a[0] = 1;
    @(negedge clk);
    n_checks++;
    if (pins_w[0] !== {3'b010, 4'b0000, 2'b01}) begin
      n_fail++;
      $display("FAIL abort_pre pins: got %b expected 010000001", pins_w[0]);
    end
    rst_a[0] = 1'b1;
    req_a[0] = 1'b0;
    #1;
    check_idle_after_reset(0, "abort_immediate");
    last_rd[0] = '0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if (pins_w[0][1] !== 1'b0) begin
        n_fail++;
        $display("FAIL abort_ack cyc%0d: got %b expected 0", c, pins_w[0][1]);
      end
    end
    rst_a[0] = 1'b0;
    ref_mem[0][8'h20] = old_v;
    do_txn(0, 0, 20'h00020, 4'b1111, 32'h0, 0, 0, 1, new_v);
    do_txn(0, 1, 20'h00020, 4'b1111, 32'h5A5A0F0F, 0, 0, 0, '0);
    do_txn(0, 0, 20'h00020, 4'b1111, 32'h0, 0, 0, 0, '0);
  endtask

`ifdef SRAM_CTRL_PERF_CNT_EN
  task automatic test_perf_cnt;
    @(negedge clk);
    we_a[0] = 0; addr_a[0] = 20'h00010; be_a[0] = 4'b1111; req_a[0] = 1;
    @(negedge clk);
    rst_a[0] = 1'b1; req_a[0] = 1'b0;
    @(negedge clk);
    rst_a[0] = 1'b0;
    last_rd[0] = '0;
    for (int k = 0; k < 3; k++)
      do_txn(0, 1, 20'(k + 40), 4'b1111, $urandom, 0, 0, 0, '0);
    for (int k = 0; k < 2; k++)
      do_txn(0, 0, 20'(k + 40), 4'b1111, 32'h0, 0, 0, 0, '0);
    @(negedge clk);
    n_checks++;
    if (wr_cnt0 !== 32'd3 || rd_cnt0 !== 32'd2) begin
      n_fail++;
      $display("FAIL perf_cnt: got wr %0d rd %0d expected wr 3 rd 2", wr_cnt0, rd_cnt0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_write_read(0);
    test_byte_write(0);
    test_write_read(1);
    test_byte_write(1);
    test_latched_inputs(0);
    test_latched_inputs(1);
    test_back_to_back(0);
    test_back_to_back(1);
    test_random();
    test_reset_mid_write();
`ifdef SRAM_CTRL_PERF_CNT_EN
    test_perf_cnt();
`endif
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
